hps_pio_responder: RTL



---
 rtl/hps_pio_responder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hps_pio_responder.sv
// hps_pio_responder
//   Avalon-MM responder on the lightweight HPS-to-FPGA bridge that replaces
//   the stock LED/switch PIO cores.
//   - LED register with per-LED hardware blink.
//   - Debounced switch register.
//   - Per-switch edge capture (W1C) with a maskable interrupt.
//
// Ports
//   clk              system clock (CLOCK50 domain)
//   reset_n          asynchronous active-low reset
//   avs_address[2:0] word address
//   avs_read         read strobe
//   avs_write        write strobe (wins over a simultaneous read)
//   avs_writedata    write data
//   avs_readdata     read data, registered, fixed latency 1, held between reads
//   irq              |(edge_capture & irq_mask)
//   switch_array_io  raw asynchronous switch inputs
//   led_array_io     LED drive, 1 = on
//
// Register map (word address)
//   0 LED_DATA [7:0] RW     3 EDGE_CAPTURE [3:0] R/W1C
//   1 SWITCH   [3:0] RO     4 BLINK_EN     [7:0] RW
//   2 IRQ_MASK [3:0] RW     5 BLINK_HALF   [BLINK_W-1:0] RW
//   6,7 read 0, writes ignored

// One switch lane: 2-flop synchronizer followed by a stability counter.
// o_chg pulses on the cycle deb is about to flip, so the capture register
// can latch on the same edge that deb changes.
module hps_pio_deb_lane #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_deb,
  output logic o_chg
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1, r_sync2, r_deb;
  logic [CW-1:0] r_cnt;
  logic          w_diff, w_hit;

  assign w_diff = r_sync2 ^ r_deb;
  assign w_hit  = w_diff && (r_cnt == CMAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_hit) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_deb = r_deb;
  assign o_chg = w_hit;
endmodule

module hps_pio_responder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_W         = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq,
  input  logic [3:0]  switch_array_io,
  output logic [7:0]  led_array_io
);
  localparam int NUM_SW = 4;

  logic [7:0]         r_led, r_blink_en;
  logic [3:0]         r_irq_mask, r_edge;
  logic [BLINK_W-1:0] r_blink_half, r_bcnt;
  logic               r_phase;
  logic [31:0]        r_rdata;

  logic [NUM_SW-1:0]  w_deb, w_chg, w_w1c;
  logic               w_rd, w_wr_half;
  logic [31:0]        w_rdmux;
  logic [31:0]        w_unused_wd;

  // Only the low bits of the write bus are stored anywhere.
  assign w_unused_wd = avs_writedata;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_lane
    hps_pio_deb_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (switch_array_io[g]),
      .o_deb   (w_deb[g]),
      .o_chg   (w_chg[g])
    );
  end

  // A write takes the cycle; a simultaneous read is dropped.
  assign w_rd      = avs_read & ~avs_write;
  assign w_wr_half = avs_write && (avs_address == 3'd5);
  assign w_w1c     = (avs_write && (avs_address == 3'd3)) ? avs_writedata[3:0] : '0;

  // Control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led        <= '0;
      r_irq_mask   <= '0;
      r_blink_en   <= '0;
      r_blink_half <= '0;
    end else if (avs_write) begin
      case (avs_address)
        3'd0:    r_led        <= avs_writedata[7:0];
        3'd2:    r_irq_mask   <= avs_writedata[3:0];
        3'd4:    r_blink_en   <= avs_writedata[7:0];
        3'd5:    r_blink_half <= avs_writedata[BLINK_W-1:0];
        default: ;
      endcase
    end
  end

  // Edge capture: a fresh deb change beats a same-cycle W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_edge <= '0;
    else          r_edge <= (r_edge & ~w_w1c) | w_chg;
  end

  // Blink timebase; a BLINK_HALF write restarts it at phase 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_wr_half || (r_blink_half == '0)) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (r_bcnt >= r_blink_half - 1'b1) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt  <= r_bcnt + 1'b1;
    end
  end

  always_comb begin
    w_rdmux = '0;
    case (avs_address)
      3'd0:    w_rdmux[7:0]         = r_led;
      3'd1:    w_rdmux[3:0]         = w_deb;
      3'd2:    w_rdmux[3:0]         = r_irq_mask;
      3'd3:    w_rdmux[3:0]         = r_edge;
      3'd4:    w_rdmux[7:0]         = r_blink_en;
      3'd5:    w_rdmux[BLINK_W-1:0] = r_blink_half;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rdmux;
  end

  assign avs_readdata = r_rdata;
  assign irq          = |(r_edge & r_irq_mask);
  assign led_array_io = r_led & ~(r_blink_en & {8{r_phase}});
endmodule
